// File: rtl/sfr_bus_arbiter.sv
// Two-requester round-robin arbiter that serialises transactions onto the SFR slave strobe bus.
// Optional WAIT timeout abort is enabled with `define SFR_ARB_TIMEOUT_EN.
module sfr_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_gnt,
    output logic                m0_done,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_gnt,
    output logic                m1_done,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,
    output logic                s_wr_en,
    output logic                s_rd_en,
    output logic [ADDR_W-1:0]   s_waddr,
    output logic [ADDR_W-1:0]   s_raddr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrobe,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_wready,
    input  logic                s_rvalid
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } xact_t;

    state_t                   state, state_nxt;
    xact_t                    cur;
    xact_t [1:0]              in_x;
    logic [1:0]               req;
    logic                     sel, owner, last_owner;
    logic [1:0]               gnt_q, done_q;
    logic [1:0][DATA_W-1:0]   rdata_q;
    logic                     resp_ok, timeout_hit, finish;

    assign req     = {m1_req, m0_req};
    assign in_x[0] = {m0_we, m0_addr, m0_wdata, m0_wstrb};
    assign in_x[1] = {m1_we, m1_addr, m1_wdata, m1_wstrb};

    // On a tie the requester that did not finish last wins.
    assign sel = (&req) ? ~last_owner : req[1];

    // Only the response type matching the latched direction counts.
    assign resp_ok = (state == WAIT) && (cur.we ? s_wready : s_rvalid);
    assign finish  = resp_ok || timeout_hit;

    assign m0_gnt   = gnt_q[0];
    assign m1_gnt   = gnt_q[1];
    assign m0_done  = done_q[0];
    assign m1_done  = done_q[1];
    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];

`ifdef SFR_ARB_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       err_q;

    assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_LAST);
    assign m0_err      = err_q[0];
    assign m1_err      = err_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            err_q    <= '0;
        end else begin
            err_q <= '0;
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + CNT_W'(1);
            // A response landing on the last cycle still wins over the abort.
            if (timeout_hit && !resp_ok)
                err_q[owner] <= 1'b1;
        end
    end
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
    assign m0_err         = 1'b0;
    assign m1_err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cur        <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            s_wr_en    <= 1'b0;
            s_rd_en    <= 1'b0;
            s_waddr    <= '0;
            s_raddr    <= '0;
            s_wdata    <= '0;
            s_wstrobe  <= '0;
        end else begin
            gnt_q   <= '0;
            done_q  <= '0;
            s_wr_en <= 1'b0;
            s_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner      <= sel;
                        cur        <= in_x[sel];
                        gnt_q[sel] <= 1'b1;
                    end
                end
                ISSUE: begin
                    s_wr_en <= cur.we;
                    s_rd_en <= ~cur.we;
                    // The bus not used by this transaction is parked at zero.
                    if (cur.we) begin
                        s_waddr   <= cur.addr;
                        s_wdata   <= cur.wdata;
                        s_wstrobe <= cur.wstrb;
                        s_raddr   <= '0;
                    end else begin
                        s_raddr   <= cur.addr;
                        s_waddr   <= '0;
                        s_wdata   <= '0;
                        s_wstrobe <= '0;
                    end
                end
                WAIT: begin
                    if (finish) begin
                        done_q[owner] <= 1'b1;
                        last_owner    <= owner;
                    end
                    if (resp_ok && !cur.we)
                        rdata_q[owner] <= s_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sfr_bus_arbiter.sv
// Bench for sfr_bus_arbiter: scripted and random requester traffic against a simple SFR slave,
// checked against a transaction-level arbitration/register model.
module tb_sfr_bus_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } tx_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mreq [2];
    logic        mwe [2];
    logic [31:0] maddr [2];
    logic [31:0] mwdata [2];
    logic [3:0]  mwstrb [2];
    logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_wr_en, s_rd_en;
    logic [31:0] s_waddr, s_raddr, s_wdata;
    logic [3:0]  s_wstrobe;
    logic [31:0] s_rdata  = '0;
    logic        s_wready = 1'b0;
    logic        s_rvalid = 1'b0;

    logic [31:0] slv_mem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    bit          suppress = 1'b0;

    always #5 clk = ~clk;

    sfr_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(mreq[0]), .m0_we(mwe[0]), .m0_addr(maddr[0]), .m0_wdata(mwdata[0]),
        .m0_wstrb(mwstrb[0]), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(mreq[1]), .m1_we(mwe[1]), .m1_addr(maddr[1]), .m1_wdata(mwdata[1]),
        .m1_wstrb(mwstrb[1]), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .s_wr_en(s_wr_en), .s_rd_en(s_rd_en), .s_waddr(s_waddr), .s_raddr(s_raddr),
        .s_wdata(s_wdata), .s_wstrobe(s_wstrobe), .s_rdata(s_rdata),
        .s_wready(s_wready), .s_rvalid(s_rvalid)
    );

    // Slave: plain 4-word register file, answers one cycle after each strobe.
    always @(posedge clk) begin
        s_wready <= 1'b0;
        s_rvalid <= 1'b0;
        if (s_wr_en && !suppress) begin
            if (s_waddr < 32'h10)
                for (int b = 0; b < 4; b++)
                    if (s_wstrobe[b]) slv_mem[s_waddr[3:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            s_wready <= 1'b1;
        end
        if (s_rd_en && !suppress) begin
            s_rdata  <= (s_raddr < 32'h10) ? slv_mem[s_raddr[3:2]] : 32'h0;
            s_rvalid <= 1'b1;
        end
    end

    logic [1:0]  gnt_v, done_v, err_v;
    logic [31:0] rdata_v [2];
    assign gnt_v      = {m1_gnt, m0_gnt};
    assign done_v     = {m1_done, m0_done};
    assign err_v      = {m1_err, m0_err};
    assign rdata_v[0] = m0_rdata;
    assign rdata_v[1] = m1_rdata;

    int          n_chk = 0, n_fail = 0, cyc = 0, act = -1;
    tx_t         q0[$], q1[$], pend [2], cur;
    bit          busy [2], gappy = 1'b0, ref_last = 1'b1;
    int          raise_c [2], gnt_c [2], lat [2], glog[$];
    logic [31:0] ref_mem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] exp_rd [2], shown_rd [2];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, {m0_gnt, m0_done, m0_err, m0_rdata, m1_gnt, m1_done, m1_err, m1_rdata,
                    s_wr_en, s_rd_en, s_waddr, s_raddr, s_wdata, s_wstrobe}, '0);
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic tx_t rnd_tx();
        tx_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = 32'(4 * $urandom_range(0, 3));
        t.wdata = $urandom;
        t.wstrb = 4'($urandom_range(1, 15));
        return t;
    endfunction

    // One cycle of the reference: sampled #1 after the edge, before inputs change.
    task automatic step();
        logic [1:0] sreq;
        sreq = {mreq[1], mreq[0]};
        if (gnt_v != 2'b00) begin
            int o;
            o = (sreq == 2'b11) ? (ref_last ? 0 : 1) : (sreq[1] ? 1 : 0);
            check("gnt_owner", gnt_v, (sreq == 2'b00) ? 2'b00 : (2'b01 << o));
            for (int m = 0; m < 2; m++)
                if (gnt_v[m] && busy[m] && mreq[m] && act < 0) begin
                    act = m; cur = pend[m]; mreq[m] = 1'b0; gnt_c[m] = cyc; glog.push_back(m);
                    if (cur.we) begin
                        if (cur.addr < 32'h10)
                            ref_mem[cur.addr[3:2]] = (ref_mem[cur.addr[3:2]] & ~strb_mask(cur.wstrb))
                                                   | (cur.wdata & strb_mask(cur.wstrb));
                    end else
                        exp_rd[m] = (cur.addr < 32'h10) ? ref_mem[cur.addr[3:2]] : 32'h0;
                end
        end
        check("strobe_excl", s_wr_en & s_rd_en, 1'b0);
        if (s_wr_en || s_rd_en) begin
            if (act >= 0) begin
                check("strobe_cycle", cyc - gnt_c[act], 1);
                check("strobe_kind", {s_wr_en, s_rd_en}, {cur.we, ~cur.we});
                check("s_waddr", s_waddr, cur.we ? cur.addr : 32'h0);
                check("s_raddr", s_raddr, cur.we ? 32'h0 : cur.addr);
                if (cur.we) check("s_wdata", {s_wdata, s_wstrobe}, {cur.wdata, cur.wstrb});
            end else
                check("strobe_spurious", {s_wr_en, s_rd_en}, 2'b00);
        end
        if (done_v != 2'b00) begin
            check("done_vec", done_v, (act >= 0) ? (2'b01 << act) : 2'b00);
            if (act >= 0 && done_v[act]) begin
                shown_rd[act] = exp_rd[act];
                check("done_latency", cyc - gnt_c[act], 3);
                lat[act] = cyc - raise_c[act];
                ref_last = act[0];
                busy[act] = 1'b0;
                act = -1;
            end
        end
        check("err_quiet", err_v, 2'b00);
        for (int m = 0; m < 2; m++) check("rdata_hold", rdata_v[m], shown_rd[m]);
        for (int m = 0; m < 2; m++)
            if (!busy[m] && (m == 0 ? q0.size() : q1.size()) > 0 &&
                (!gappy || $urandom_range(0, 2) != 0)) begin
                pend[m] = (m == 0) ? q0.pop_front() : q1.pop_front();
                mwe[m] = pend[m].we; maddr[m] = pend[m].addr;
                mwdata[m] = pend[m].wdata; mwstrb[m] = pend[m].wstrb;
                mreq[m] = 1'b1; busy[m] = 1'b1; raise_c[m] = cyc;
            end
    endtask

    task automatic run(input int budget);
        int start;
        bit expired;
        start = cyc; expired = 1'b0;
        while (q0.size() > 0 || q1.size() > 0 || busy[0] || busy[1]) begin
            if (cyc - start > budget) begin expired = 1'b1; break; end
            @(posedge clk); #1; cyc++;
            step();
        end
        check("run_budget", expired, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 1'b0; mwe[m] = 1'b0; maddr[m] = '0; mwdata[m] = '0; mwstrb[m] = '0;
            busy[m] = 1'b0; exp_rd[m] = '0; shown_rd[m] = '0; lat[m] = 0;
        end
        repeat (2) @(posedge clk);
        #1 check_zero("reset_outputs");
        reset_n = 1'b1;

        // Single write, then a read of the same register from the other side.
        q0.push_back('{1'b1, 32'h4, 32'hDEADBEEF, 4'hF});
        run(40);
        check("wr_latency", lat[0], 4);
        check("wr_gnt_count", glog.size(), 1);
        q1.push_back('{1'b0, 32'h4, 32'h0, 4'h0});
        run(40);
        check("rd_latency", lat[1], 4);
        check("rd_m1_rdata", m1_rdata, 32'hDEADBEEF);
        check("rd_m0_rdata", m0_rdata, 32'h0);

        // Both requesters saturated: grants must alternate starting with m0.
        glog.delete();
        for (int i = 0; i < 3; i++) begin q0.push_back(rnd_tx()); q1.push_back(rnd_tx()); end
        run(200);
        check("rr_count", glog.size(), 6);
        for (int i = 0; i < glog.size() && i < 6; i++) check("rr_order", glog[i], i % 2);

        gappy = 1'b1;
        for (int i = 0; i < 8; i++) begin q0.push_back(rnd_tx()); q1.push_back(rnd_tx()); end
        run(800);
        gappy = 1'b0;

        // Reset while an m1 read is stuck in WAIT.
        suppress = 1'b1;
        mwe[1] = 1'b0; maddr[1] = 32'h4; mreq[1] = 1'b1;
        @(posedge clk); #1 check("rst_gnt", m1_gnt, 1'b1);
        mreq[1] = 1'b0;
        @(posedge clk); #1 check("rst_strobe", {s_rd_en, s_raddr}, {1'b1, 32'h4});
        @(posedge clk); #1 reset_n = 1'b0;
        #1 check_zero("rst_async");
        repeat (2) begin @(posedge clk); #1 check_zero("rst_hold"); end
        reset_n = 1'b1; suppress = 1'b0; ref_last = 1'b1; act = -1;
        for (int m = 0; m < 2; m++) begin exp_rd[m] = '0; shown_rd[m] = '0; end
        q0.push_back('{1'b0, 32'h4, 32'h0, 4'h0});
        run(40);
        check("post_rst_latency", lat[0], 4);

        // Out-of-range read still completes because the slave answers it.
        q0.push_back('{1'b0, 32'h10, 32'h0, 4'h0});
        run(40);
        check("oob_latency", lat[0], 4);
        check("oob_rdata", m0_rdata, 32'h0);

`ifdef SFR_ARB_TIMEOUT_EN
        begin
            int dc, g1, d1;
            logic e0;
            dc = -1; g1 = -1; d1 = -1; e0 = 1'b0;
            suppress = 1'b1;
            mwe[0] = 1'b0; maddr[0] = 32'h8; mreq[0] = 1'b1;
            for (int c = 1; c <= 14; c++) begin
                @(posedge clk); #1;
                if (m0_gnt) begin
                    mreq[0] = 1'b0;
                    mwe[1] = 1'b0; maddr[1] = 32'h8; mreq[1] = 1'b1;
                end
                if (m0_done) begin dc = c; e0 = m0_err; end
                if (m1_gnt) begin g1 = c; mreq[1] = 1'b0; suppress = 1'b0; end
                if (m1_done && d1 < 0) begin
                    d1 = c;
                    check("to_m1_rdata", m1_rdata, ref_mem[2]);
                    check("to_m1_err", m1_err, 1'b0);
                end
                check("to_m0_rdata", m0_rdata, shown_rd[0]);
            end
            check("to_done_cycle", dc, 6);
            check("to_err", e0, 1'b1);
            check("to_m1_gnt", g1, 7);
            check("to_m1_done", d1, 10);
            shown_rd[1] = ref_mem[2]; ref_last = 1'b1;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sfr_bus_arbiter.md
Name: sfr_bus_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port SFR register slave (control/intr_sts/intr_msk/debug at 0x0/0x4/0x8/0xC).
- Serialises requester transactions onto the slave's wr_en/rd_en strobe interface.
- Waits for o_wready/o_rvalid and returns completion and read data to the owning requester.
- Exactly one transaction is outstanding at the slave at any time.

Parameters:
- ADDR_W, 32, address width of requester and slave buses.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- TIMEOUT, 16, max cycles in WAIT before forced abort; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_req  in  1  requester 0 transaction request; held until m0_gnt.
- m0_we  in  1  1=write, 0=read.
- m0_addr  in  ADDR_W  byte address.
- m0_wdata  in  DATA_W  write data.
- m0_wstrb  in  DATA_W/8  write byte strobes.
- m0_gnt  out  1  one-cycle pulse: request accepted and latched.
- m0_done  out  1  one-cycle pulse: transaction complete.
- m0_rdata  out  DATA_W  read data, valid with m0_done on reads.
- m0_err  out  1  one-cycle pulse with m0_done on timeout abort (0 if feature off).
- m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_gnt, m1_done, m1_rdata, m1_err  same as m0_* for requester 1.
- s_wr_en  out  1  slave write strobe.
- s_rd_en  out  1  slave read strobe.
- s_waddr  out  ADDR_W  slave write address.
- s_raddr  out  ADDR_W  slave read address.
- s_wdata  out  DATA_W  slave write data.
- s_wstrobe  out  DATA_W/8  slave write strobes.
- s_rdata  in  DATA_W  slave read data.
- s_wready  in  1  slave write acknowledge.
- s_rvalid  in  1  slave read-data valid.

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_owner=1 (so m0 wins first tie). All outputs 0: gnt, done, err, rdata, s_* strobes, addr, data, wstrobe.
- All outputs are registered. Reset mid-transaction drops the transaction; no done is issued.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req is high, select owner: only one requester -> that one; both -> the one != last_owner.
  - Latch we/addr/wdata/wstrb of the owner, pulse its gnt next cycle, go to ISSUE.
  - Requester must drop req the cycle after gnt; req still high on the next IDLE visit counts as a new request.
- ISSUE:
  - Drive s_wr_en (we=1) or s_rd_en (we=0) high for exactly one cycle; never both.
  - Drive s_waddr/s_wdata/s_wstrobe (write) or s_raddr (read) from the latch; the unused address bus holds 0.
  - Go to WAIT.
- WAIT:
  - Strobes are low; address/data remain stable.
  - Write: s_wready=1 completes. Read: s_rvalid=1 completes; capture s_rdata into owner rdata.
  - On completion: pulse owner done next cycle, set last_owner=owner, go to IDLE.
  - s_rvalid during a write, or s_wready during a read, is ignored.
- Responses arriving in IDLE/ISSUE are ignored.
- rdata holds its last captured value until the next read completion for that requester; writes do not modify it.
- Latency (slave responds one cycle after strobe):
  - req high at edge 0 -> gnt after edge 1 -> strobe after edge 2 -> slave response after edge 3 -> done after edge 4.
  - Back-to-back throughput is one transaction per 4 cycles.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- Addresses are passed through unchecked; decode is the slave's job.

Optional Feature:
- Macro SFR_ARB_TIMEOUT_EN.
- Defined: a counter cleared on entering WAIT increments each WAIT cycle. When it reaches TIMEOUT without a response:
  - pulse owner done and err together; rdata is unchanged;
  - set last_owner=owner and return to IDLE;
  - a late slave response is ignored.
- Not defined: no counter; WAIT holds indefinitely; err outputs tied 0.

Test Plan:
- Reset, then m0 write addr 0x4 data 0xDEADBEEF strb 0xF -> m0_gnt one cycle, s_wr_en one cycle with s_waddr=0x4; m0_done 4 cycles after req; m1_* stay 0.
- m1 read addr 0x4 after the previous write -> s_rd_en one cycle with s_raddr=0x4; m1_done with m1_rdata=0xDEADBEEF; m0_rdata unchanged.
- m0 and m1 assert req in the same cycle after reset, each re-requesting after done, 3 rounds -> grant order m0,m1,m0,m1,m0,m1; never two strobes while in WAIT.
- Assert reset_n=0 while in WAIT on an m1 read -> all outputs 0 immediately; no m1_done; m0 request after release is served normally.
- m0 read of 0x10 (slave still asserts rvalid) -> completes without hang; m0_done pulses and m0_err=0.
- With SFR_ARB_TIMEOUT_EN and TIMEOUT=4, slave response suppressed -> m0_done and m0_err pulse 4 cycles after WAIT entry; a pending m1 request is granted next.
